// File: rtl/dmem_if.sv
// Load/store request/response handshake between the MEM stage and data memory.
// The core drives the master side; the memory responder drives the slave side.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage.
// One request in flight; stores commit with byte enables at accept.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state, nxt;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        oob;
  logic [AW-1:0] idx;
  logic        unused_ok;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  assign idx       = bus.req_addr[AW+1:2];
  assign oob       = bus.req_addr[31:2] >= 30'(DEPTH_WORDS);
  assign accept    = (state == IDLE) && bus.req_valid;
  assign unused_ok = ^bus.req_addr[1:0];

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept)
              nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY: if (cnt == 4'd1)
              nxt = RESP;
      RESP: if (bus.resp_ready)
              nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        err_q   <= oob;
        rdata_q <= (bus.req_we || oob) ? '0 : mem[idx];
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Memory contents survive reset; rst only blocks a same-edge commit.
  always_ff @(posedge clk) begin
    if (!rst && accept && bus.req_we && !oob) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_be[i])
          mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus
// backpressure and mid-operation reset sequences.
module tb_dmem_responder;
  localparam int L = 2;
  localparam int D = 256;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  dmem_if bus ();

  dmem_responder #(
    .DEPTH_WORDS(D),
    .LATENCY    (L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xact(input string nm, input logic we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] ed,
                      input logic ee);
    int cyc;
    @(negedge clk);
    chk({nm, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = 32'h0000_0010;
    bus.req_wdata = ~d;
    bus.req_be    = 4'hF;
    cyc = 0;
    while (!bus.resp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " lat"}, 32'(cyc), 32'(L - 1));
    chk({nm, " rdata"}, bus.resp_rdata, ed);
    chk({nm, " err"}, 32'(bus.resp_err), 32'(ee));
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk({nm, " post"}, {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
  endtask

  initial begin
    vt[0]  = '{"st10",   1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    vt[1]  = '{"ld10",   1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{"st14",   1'b1, 32'h14,  32'h11223344, 4'hF, 32'h0, 1'b0};
    vt[3]  = '{"st14b1", 1'b1, 32'h14,  32'h0000AA00, 4'h2, 32'h0, 1'b0};
    vt[4]  = '{"ld14a",  1'b0, 32'h14,  32'h0,        4'hF, 32'h1122AA44, 1'b0};
    vt[5]  = '{"st14b0", 1'b1, 32'h14,  32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
    vt[6]  = '{"ld14b",  1'b0, 32'h16,  32'h0,        4'h0, 32'h1122AA44, 1'b0};
    vt[7]  = '{"st0",    1'b1, 32'h0,   32'h0BADF00D, 4'hF, 32'h0, 1'b0};
    vt[8]  = '{"st400",  1'b1, 32'h400, 32'h12345678, 4'hF, 32'h0, 1'b1};
    vt[9]  = '{"ld400",  1'b0, 32'h400, 32'h0,        4'h0, 32'h0, 1'b1};
    vt[10] = '{"ld0",    1'b0, 32'h0,   32'h0,        4'h0, 32'h0BADF00D, 1'b0};
    vt[11] = '{"st3fc",  1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0};
    vt[12] = '{"st3fcb", 1'b1, 32'h3FC, 32'h77660000, 4'hC, 32'h0, 1'b0};
    vt[13] = '{"ld3fc",  1'b0, 32'h3FC, 32'h0,        4'h0, 32'h7766A5A5, 1'b0};
    vt[14] = '{"ldhi",   1'b0, 32'h8000_0010, 32'h0,  4'h0, 32'h0, 1'b1};
    vt[15] = '{"ld10b",  1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_be     = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", 32'(bus.req_ready), 32'd1);
    chk("rst valid", 32'(bus.resp_valid), 32'd0);
    chk("rst rdata", bus.resp_rdata, 32'd0);
    chk("rst err", 32'(bus.resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      xact(vt[i].nm, vt[i].we, vt[i].a, vt[i].d, vt[i].be,
           vt[i].ed, vt[i].ee);

    // Backpressure: hold response, poke ignored store at 0x10.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h10;
    @(posedge clk); #1;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'h0;
    bus.req_be    = 4'hF;
    @(posedge clk); #1;
    chk("bp valid0", 32'(bus.resp_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp valid", 32'(bus.resp_valid), 32'd1);
      chk("bp rdata", bus.resp_rdata, 32'hDEADBEEF);
      chk("bp ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("bp rel ready", 32'(bus.req_ready), 32'd1);
    chk("bp rel valid", 32'(bus.resp_valid), 32'd0);
    xact("bp ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Reset during BUSY discards the response but keeps the store.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hCAFEF00D;
    bus.req_be    = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("mr busy", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr ready", 32'(bus.req_ready), 32'd1);
    chk("mr valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("mr idle valid", 32'(bus.resp_valid), 32'd0);
    end
    xact("mr ld20", 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
